layer_output_serializer: RTL and testbench

- Sits directly downstream of one layer of neuron instances.
- Captures the layer's NUM_NEURONS parallel outputs when the layer's outvalid strobes fire together.
- Replays the captured outputs one word per cycle as the myinput/myinputValid stream that the next layer's neurons consume.
- Flags overrun and misaligned-valid conditions for debug.

---
 rtl/layer_output_serializer_pkg.sv | 22 ++
 rtl/layer_output_serializer.sv | 159 +++++++++++++++
 tb/tb_layer_output_serializer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_output_serializer_pkg.sv
// -----------------------------------------------------------------------------
// layer_output_serializer_pkg
//
// Shared definitions for the layer glue blocks that sit between neuron layers.
//   ser_state_e : two-state serializer FSM encoding (IDLE, SHIFT)
//   clog2_min1  : ceil(log2(n)) with a floor of 1. A counter over a
//                 single-entry range still needs one bit.
// -----------------------------------------------------------------------------
package layer_output_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// -----------------------------------------------------------------------------
// layer_output_serializer
//
// Captures the NUM_NEURONS parallel outputs of one neuron layer when every
// outvalid strobe fires together. It then replays those words one per beat,
// neuron 0 first, as the myinput / myinputValid stream for the next layer.
//
// Optional build macro:
//   SER_BACKPRESSURE_EN - when defined, out_ready gates each beat, and the
//                         output word holds while out_valid & !out_ready.
//                         When undefined, out_ready is ignored and a burst
//                         always takes exactly NUM_NEURONS cycles.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   neuron_out     in   NUM_NEURONS*dataWidth; neuron k at [k*dataWidth +: dataWidth]
//   neuron_valid   in   per-neuron outvalid strobes
//   out_ready      in   downstream accept (backpressure builds only)
//   out_data       out  serial word (registered)
//   out_valid      out  serial word valid (registered)
//   busy           out  high while a burst is being shifted out
//   overrun        out  sticky: a full capture arrived mid-burst and was dropped
//   valid_mismatch out  sticky: some, but not all, outvalid strobes fired
// -----------------------------------------------------------------------------
module layer_output_serializer
    import layer_output_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int dataWidth   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_NEURONS*dataWidth-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]           neuron_valid,
    input  logic                             out_ready,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun,
    output logic                             valid_mismatch
);

    localparam int               IDX_W    = clog2_min1(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    ser_state_e           state;
    ser_state_e           state_next;
    logic [IDX_W-1:0]     index;
    logic [dataWidth-1:0] buffer [NUM_NEURONS];

    logic cap;          // the whole layer presented a result together
    logic partial;      // some strobes fired without the others
    logic beat_ok;      // the downstream side lets the current word advance
    logic beat_done;    // the current word advances at this edge
    logic final_done;   // the last word of the burst advances at this edge
    logic load;         // accept a new capture into the buffer
    logic drop;         // a capture arrived while the buffer was still needed

    assign cap     = &neuron_valid;
    assign partial = (|neuron_valid) & ~cap;

`ifdef SER_BACKPRESSURE_EN
    assign beat_ok = out_valid & out_ready;
`else
    // A word is on the bus for exactly one cycle. out_ready is deliberately
    // ignored and only kept so the port list does not depend on the build.
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign beat_ok          = 1'b1;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        beat_done  = 1'b0;
        final_done = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;

        case (state)
            IDLE: begin
                if (cap) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                beat_done  = beat_ok;
                final_done = beat_ok && (index == LAST_IDX);
                // A capture that lands exactly on the last beat chains
                // straight into the next burst with no idle cycle between.
                if (cap && final_done) begin
                    load = 1'b1;
                end else if (cap) begin
                    drop = 1'b1;
                end
                if (final_done && !cap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the capture buffer has no reset. It is always written before it
    // is read, and leaving it out of reset keeps it a plain register bank.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                buffer[k] <= neuron_out[k*dataWidth +: dataWidth];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index          <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            overrun        <= 1'b0;
            valid_mismatch <= 1'b0;
        end else begin
            if (load) begin
                // Neuron 0 is presented straight from the inputs because the
                // buffer is only being written at this same edge.
                index     <= '0;
                out_data  <= neuron_out[dataWidth-1:0];
                out_valid <= 1'b1;
            end else if (final_done) begin
                out_valid <= 1'b0;
            end else if (beat_done) begin
                index    <= index + IDX_W'(1);
                out_data <= buffer[index + IDX_W'(1)];
            end

            if (drop) begin
                overrun <= 1'b1;
            end
            if (partial) begin
                valid_mismatch <= 1'b1;
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_layer_output_serializer.sv
// -----------------------------------------------------------------------------
// tb_layer_output_serializer
//
// Directed bench for layer_output_serializer with NUM_NEURONS=4, dataWidth=16.
// The reference model is a queue of words still owed downstream, plus the two
// sticky flags. A separate compare process checks the DUT against that model
// on every cycle. The words seen downstream are also collected and compared
// with hand-written lists, so the model itself is pinned as well.
// Define SER_BACKPRESSURE_EN for both the bench and the RTL to run the
// out_ready scenario.
// -----------------------------------------------------------------------------
module tb_layer_output_serializer;

    localparam int NN = 4;
    localparam int DW = 16;
`ifdef SER_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NN*DW-1:0] neuron_out;
    logic [NN-1:0]    neuron_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic             valid_mismatch;

    layer_output_serializer #(.NUM_NEURONS(NN), .dataWidth(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .neuron_out     (neuron_out),
        .neuron_valid   (neuron_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .busy           (busy),
        .overrun        (overrun),
        .valid_mismatch (valid_mismatch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds the words that are still to be delivered. Its head is the
    // word on the bus now, and a burst is in progress whenever it is not empty.
    logic [DW-1:0] exp_q [$];
    bit            exp_ovr;
    bit            exp_mm;
    bit            m_cap;
    bit            m_done;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_ovr = 1'b0;
            exp_mm  = 1'b0;
        end else begin
            m_cap = (neuron_valid == {NN{1'b1}});
            if (neuron_valid != '0 && !m_cap) exp_mm = 1'b1;
            m_done = (exp_q.size() != 0) && (BP ? out_ready : 1'b1);
            if (m_done) void'(exp_q.pop_front());
            if (m_cap) begin
                // The capture is taken only if nothing is left to send after this edge.
                if (exp_q.size() == 0) begin
                    for (int k = 0; k < NN; k++) exp_q.push_back(neuron_out[k*DW +: DW]);
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    bit            chk_en = 1'b0;
    logic [DW-1:0] seen [$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            check("valid_mismatch", 32'(valid_mismatch), 32'(exp_mm));
            if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_valid === 1'b1 && (!BP || out_ready === 1'b1)) seen.push_back(out_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_seen(input string name, input logic [DW-1:0] e [8], input int n);
        check({name, "_count"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++) begin
            check(name, 32'(seen[i]), 32'(e[i]));
        end
        seen.delete();
    endtask

    localparam logic [NN*DW-1:0] WORDS_A = 64'h0004_0003_0002_0001;
    localparam logic [NN*DW-1:0] WORDS_B = 64'h00D4_00C3_00B2_00A1;

    logic [DW-1:0] e8 [8];

    initial begin
        rst          = 1'b1;
        neuron_out   = '0;
        neuron_valid = '0;
        out_ready    = 1'b1;
        tick(2);
        chk_en = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1. basic burst
        neuron_out = WORDS_A; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_data", 32'(out_data), 32'h0001);
        tick(3);
        check("t1_last_data", 32'(out_data), 32'h0004);
        tick(1);
        check("t1_end_valid", 32'(out_valid), 32'd0);
        check("t1_end_busy", 32'(busy), 32'd0);
        tick(2);
        e8 = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0};
        check_seen("t1_words", e8, 4);

        // 2. back-to-back: the second capture lands on the final-beat edge
        neuron_out = WORDS_A; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        tick(3);
        neuron_out = WORDS_B; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        check("t2_chain_valid", 32'(out_valid), 32'd1);
        check("t2_chain_data", 32'(out_data), 32'h00A1);
        tick(6);
        check("t2_overrun", 32'(overrun), 32'd0);
        e8 = '{16'h1, 16'h2, 16'h3, 16'h4, 16'hA1, 16'hB2, 16'hC3, 16'hD4};
        check_seen("t2_words", e8, 8);

        // 3. overrun: the second capture lands during beat 2
        neuron_out = WORDS_A; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        tick(1);
        neuron_out = WORDS_B; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        tick(6);
        check("t3_overrun", 32'(overrun), 32'd1);
        e8 = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0};
        check_seen("t3_words", e8, 4);

        // 4. partial strobes in IDLE
        neuron_out = WORDS_B; neuron_valid = 4'b0111;
        tick(1);
        neuron_valid = 4'h0;
        tick(2);
        check("t4_mismatch", 32'(valid_mismatch), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        check("t4_no_words", 32'(seen.size()), 32'd0);

        // 5. reset during beat 3, then a fresh burst
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        seen.delete();
        neuron_out = WORDS_A; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        tick(2);
        check("t5_beat3", 32'(out_data), 32'h0003);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data", 32'(out_data), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_mismatch", 32'(valid_mismatch), 32'd0);
        tick(2);
        e8 = '{16'h1, 16'h2, 16'h3, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        check_seen("t5_cut_words", e8, 3);
        neuron_out = WORDS_A; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        tick(6);
        e8 = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0};
        check_seen("t5_restart_words", e8, 4);

`ifdef SER_BACKPRESSURE_EN
        // 6. stall beat 2 for three cycles
        neuron_out = WORDS_A; neuron_valid = 4'hF;
        tick(1);
        neuron_valid = 4'h0;
        tick(1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t6_hold_data", 32'(out_data), 32'h0002);
            check("t6_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick(3);
        check("t6_last_data", 32'(out_data), 32'h0004);
        tick(1);
        check("t6_end_valid", 32'(out_valid), 32'd0);
        tick(2);
        e8 = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0};
        check_seen("t6_words", e8, 4);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
